// File: rtl/logisim_tick_clock.sv
// Derived circuit clock driven by FPGATick strobes: programmable high/low tick counts,
// an initial phase delay and one-cycle edge strobes. Optional single-step: LOGISIM_TICK_CLOCK_STEP_EN.
module logisim_tick_clock #(
  parameter int unsigned HighTicks = 2,
  parameter int unsigned LowTicks  = 2,
  parameter int unsigned Phase     = 0,
  parameter int unsigned CntBits   = 8
) (
  input  logic FPGAClock,
  input  logic Reset,
  input  logic FPGATick,
  input  logic Run,
`ifdef LOGISIM_TICK_CLOCK_STEP_EN
  input  logic Step,
  output logic StepDone,
`endif
  output logic ClockOut,
  output logic RiseTick,
  output logic FallTick
);

  typedef enum logic [1:0] {
    S_DELAY = 2'd0,
    S_LOW   = 2'd1,
    S_HIGH  = 2'd2
  } state_t;

  localparam logic [CntBits-1:0] HIGH_RELOAD  = CntBits'(HighTicks - 32'd1);
  localparam logic [CntBits-1:0] LOW_RELOAD   = CntBits'(LowTicks - 32'd1);
  localparam logic [CntBits-1:0] PHASE_RELOAD = CntBits'((Phase > 0) ? (Phase - 32'd1) : 32'd0);
  localparam state_t             RESET_STATE  = (Phase > 0) ? S_DELAY : S_LOW;
  localparam logic [CntBits-1:0] RESET_CNT    = (Phase > 0) ? PHASE_RELOAD : LOW_RELOAD;

  if (HighTicks < 1 || LowTicks < 1) begin : g_param_check
    $error("logisim_tick_clock: HighTicks and LowTicks must both be >= 1");
  end

  state_t             state_q, state_d;
  logic [CntBits-1:0] cnt_q, cnt_d;
  logic               advance;
  logic               force_edge;
  logic               rise_d, fall_d;
  logic               pending_q, pending_d;
  logic               step_done_d;

  // Next-state: normal tick countdown, or a forced transition from a pending step
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    pending_d   = pending_q;
    step_done_d = 1'b0;
    force_edge  = 1'b0;
    advance     = FPGATick && Run;

`ifdef LOGISIM_TICK_CLOCK_STEP_EN
    if (pending_q) begin
      if (Run) begin
        pending_d = 1'b0;
      end else if (FPGATick) begin
        force_edge  = 1'b1;
        pending_d   = 1'b0;
        step_done_d = 1'b1;
      end
    end else if (Step && !Run) begin
      pending_d = 1'b1;
    end
`endif

    if (advance || force_edge) begin
      case (state_q)
        S_DELAY: begin
          if (force_edge || cnt_q == '0) begin
            state_d = S_LOW;
            cnt_d   = LOW_RELOAD;
          end else begin
            cnt_d = cnt_q - CntBits'(1);
          end
        end
        S_LOW: begin
          if (force_edge || cnt_q == '0) begin
            state_d = S_HIGH;
            cnt_d   = HIGH_RELOAD;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CntBits'(1);
          end
        end
        S_HIGH: begin
          if (force_edge || cnt_q == '0) begin
            state_d = S_LOW;
            cnt_d   = LOW_RELOAD;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CntBits'(1);
          end
        end
        default: begin
          state_d = RESET_STATE;
          cnt_d   = RESET_CNT;
        end
      endcase
    end
  end

  always_ff @(posedge FPGAClock) begin
    if (Reset) begin
      state_q   <= RESET_STATE;
      cnt_q     <= RESET_CNT;
      ClockOut  <= 1'b0;
      RiseTick  <= 1'b0;
      FallTick  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ClockOut  <= (state_d == S_HIGH);
      RiseTick  <= rise_d;
      FallTick  <= fall_d;
      pending_q <= pending_d;
    end
  end

`ifdef LOGISIM_TICK_CLOCK_STEP_EN
  always_ff @(posedge FPGAClock) begin
    if (Reset) begin
      StepDone <= 1'b0;
    end else begin
      StepDone <= step_done_d;
    end
  end
`endif

endmodule

// File: tb/tb_logisim_tick_clock.sv
// Randomised bench for logisim_tick_clock: three parameterisations checked each cycle
// against a tick-timeline model, plus literal waveform pins for the documented scenarios.
module tb_logisim_tick_clock;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst  = 1'b1;
  logic tick = 1'b0;
  logic run  = 1'b0;
  logic step = 1'b0;
  logic [2:0] clk_o, rise_o, fall_o, sd_o;

  localparam int HT [3] = '{2, 1, 3};
  localparam int LT [3] = '{3, 1, 2};
  localparam int PH [3] = '{0, 2, 1};

  logisim_tick_clock #(.HighTicks(2), .LowTicks(3), .Phase(0), .CntBits(8)) dut_a (
    .FPGAClock(clk), .Reset(rst), .FPGATick(tick), .Run(run),
`ifdef LOGISIM_TICK_CLOCK_STEP_EN
    .Step(step), .StepDone(sd_o[0]),
`endif
    .ClockOut(clk_o[0]), .RiseTick(rise_o[0]), .FallTick(fall_o[0]));

  logisim_tick_clock #(.HighTicks(1), .LowTicks(1), .Phase(2), .CntBits(4)) dut_b (
    .FPGAClock(clk), .Reset(rst), .FPGATick(tick), .Run(run),
`ifdef LOGISIM_TICK_CLOCK_STEP_EN
    .Step(step), .StepDone(sd_o[1]),
`endif
    .ClockOut(clk_o[1]), .RiseTick(rise_o[1]), .FallTick(fall_o[1]));

  logisim_tick_clock #(.HighTicks(3), .LowTicks(2), .Phase(1), .CntBits(3)) dut_c (
    .FPGAClock(clk), .Reset(rst), .FPGATick(tick), .Run(run),
`ifdef LOGISIM_TICK_CLOCK_STEP_EN
    .Step(step), .StepDone(sd_o[2]),
`endif
    .ClockOut(clk_o[2]), .RiseTick(rise_o[2]), .FallTick(fall_o[2]));

`ifndef LOGISIM_TICK_CLOCK_STEP_EN
  assign sd_o = 3'b000;
`endif

  int checks = 0;
  int errors = 0;

  // Model: each instance is a position t on an infinite tick timeline
  int t [3];
  bit e_clk [3];
  bit e_rise [3];
  bit e_fall [3];
  bit e_sd [3];
  bit pend [3];

  function automatic bit wave(int i, int tt);
    int p;
    if (tt < PH[i]) return 1'b0;
    p = (tt - PH[i]) % (LT[i] + HT[i]);
    return (p >= LT[i]);
  endfunction

  function automatic int next_bound(int i, int tt);
    int p;
    if (tt < PH[i]) return PH[i];
    p = (tt - PH[i]) % (LT[i] + HT[i]);
    return (p < LT[i]) ? (tt - p + LT[i]) : (tt - p + LT[i] + HT[i]);
  endfunction

  task automatic model_step();
    bit forced;
    bit nw;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        t[i] = 0; e_clk[i] = 0; e_rise[i] = 0; e_fall[i] = 0; e_sd[i] = 0; pend[i] = 0;
      end else begin
        forced = 0;
        e_sd[i] = 0;
`ifdef LOGISIM_TICK_CLOCK_STEP_EN
        if (pend[i]) begin
          if (run) pend[i] = 0;
          else if (tick) begin forced = 1; pend[i] = 0; e_sd[i] = 1; end
        end else if (step && !run) begin
          pend[i] = 1;
        end
`endif
        if (forced) t[i] = next_bound(i, t[i]);
        else if (tick && run) t[i] = t[i] + 1;
        nw = wave(i, t[i]);
        e_rise[i] = nw & ~e_clk[i];
        e_fall[i] = ~nw & e_clk[i];
        e_clk[i] = nw;
      end
    end
  endtask

  task automatic check(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("clock_out[%0d]", i), clk_o[i], e_clk[i]);
      check($sformatf("rise_tick[%0d]", i), rise_o[i], e_rise[i]);
      check($sformatf("fall_tick[%0d]", i), fall_o[i], e_fall[i]);
`ifdef LOGISIM_TICK_CLOCK_STEP_EN
      check($sformatf("step_done[%0d]", i), sd_o[i], e_sd[i]);
`endif
    end
  endtask

  // Reset edge then five ticks; sample s0 is the reset edge
  task automatic t1_seq();
    logic [5:0] a_clk, a_rise, a_fall, b_clk;
    logic [5:0] ex_a_clk, ex_a_rise, ex_a_fall, ex_b_clk;
    ex_a_clk  = 6'b011000;
    ex_a_rise = 6'b001000;
    ex_a_fall = 6'b100000;
    ex_b_clk  = 6'b101000;
    rst = 1; tick = 1; run = 1; step = 0;
    cycle();
    a_clk[0] = clk_o[0]; a_rise[0] = rise_o[0]; a_fall[0] = fall_o[0]; b_clk[0] = clk_o[1];
    rst = 0;
    for (int k = 1; k < 6; k++) begin
      cycle();
      a_clk[k] = clk_o[0]; a_rise[k] = rise_o[0]; a_fall[k] = fall_o[0]; b_clk[k] = clk_o[1];
    end
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t1_clock s%0d", k), a_clk[k], ex_a_clk[k]);
      check($sformatf("t1_rise s%0d", k), a_rise[k], ex_a_rise[k]);
      check($sformatf("t1_fall s%0d", k), a_fall[k], ex_a_fall[k]);
      check($sformatf("t3_clock s%0d", k), b_clk[k], ex_b_clk[k]);
    end
  endtask

  initial begin
    int first_rise;
    int second_rise;
    bit found;

    rst = 1; tick = 0; run = 0; step = 0;
    cycle();
    cycle();

    // T1 / T3
    t1_seq();

    // T6: reach HIGH, reset for one cycle, then the T1 sequence again
    rst = 0; tick = 1; run = 1;
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      cycle();
      if (clk_o[0] === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL t6_reach_high: got timeout expected ClockOut=1 within 50 cycles");
    end
    t1_seq();

    // T4: freeze in mid-HIGH with cnt=1
    rst = 1; tick = 1; run = 1;
    cycle();
    rst = 0;
    for (int k = 0; k < 3; k++) cycle();
    check("t4_entry_clock", clk_o[0], 1'b1);
    check("t4_entry_rise", rise_o[0], 1'b1);
    run = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("t4_hold_clock", clk_o[0], 1'b1);
      check("t4_hold_rise", rise_o[0], 1'b0);
      check("t4_hold_fall", fall_o[0], 1'b0);
    end
    run = 1;
    cycle();
    check("t4_tick1_clock", clk_o[0], 1'b1);
    check("t4_tick1_fall", fall_o[0], 1'b0);
    cycle();
    check("t4_tick2_clock", clk_o[0], 1'b0);
    check("t4_tick2_fall", fall_o[0], 1'b1);

    // T2: tick every 4th cycle, period between rises is 20 cycles
    rst = 1; tick = 0; run = 1;
    cycle();
    rst = 0;
    first_rise = -1; second_rise = -1;
    for (int k = 0; k < 45; k++) begin
      tick = (k % 4 == 3);
      cycle();
      if (rise_o[0] === 1'b1) begin
        if (first_rise < 0) first_rise = k;
        else if (second_rise < 0) second_rise = k;
      end
    end
    tick = 0;
    checks++;
    if (first_rise < 0 || second_rise < 0 || second_rise - first_rise != 20) begin
      errors++;
      $display("FAIL t2_period: got %0d expected 20", second_rise - first_rise);
    end

`ifdef LOGISIM_TICK_CLOCK_STEP_EN
    // T5: single step from LOW cnt=2 while frozen
    rst = 1; tick = 0; run = 0; step = 0;
    cycle();
    rst = 0; step = 1;
    cycle();
    cycle();
    step = 0; tick = 1;
    cycle();
    check("t5_clock", clk_o[0], 1'b1);
    check("t5_rise", rise_o[0], 1'b1);
    check("t5_step_done", sd_o[0], 1'b1);
    cycle();
    check("t5_after_clock", clk_o[0], 1'b1);
    check("t5_after_rise", rise_o[0], 1'b0);
    check("t5_after_step_done", sd_o[0], 1'b0);
`endif

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      rst  = ($urandom_range(0, 99) == 0);
      tick = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) run = ~run;
      step = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
